stage5_lane_scheduler: RTL
==========================

// Module: stage5_lane_scheduler
// PURPOSE
// - Packs the incoming parsed-message stream into 3-lane batches for the stage-5 field extractors (EBSN4 and siblings).
// - Drives message_en, message_1..3, message_mux_control_m1..3 and N_type_control_m1..3 from registers.
// - Sits between the stage-4 message buffer (valid/ready) and the combinational stage-5 extractor bank.
// PARAMETERS
// - MSG_W    `MAX_MESSAGE_BITS              message width per lane
// - MUX_W    `message_mux_control_width     mux-control width
// - NT_W     `N_type_control_width          N-type control width
// - TIMEOUT  16                             idle cycles before a partial batch is flushed (BATCH_TIMEOUT_EN only)
// PORTS
// - clk                     in   1      single clock, rising edge
// - rst                     in   1      synchronous, active-high reset
// - in_valid                in   1      upstream message valid
// - in_ready                out  1      scheduler accepts message this cycle
// - in_message              in   MSG_W  message payload
// - in_mux                  in   MUX_W  message mux class
// - in_ntype                in   NT_W   N-type subclass
// - in_last                 in   1      flush current batch after this message
// - out_ready               in   1      extractor/result stage accepts the issued batch
// - message_en              out  1      batch valid to stage 5
// - message_1..3            out  MSG_W  lane payloads
// - message_mux_control_m1..3 out MUX_W lane mux class; `message_mux_NULL on empty lane
// - N_type_control_m1..3    out  NT_W   lane N-type; `N_type_NULL on empty lane
// - lane_fill               out  2      lanes occupied in the current/issued batch (0..3)
// - batch_cnt               out  16     issued batches, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE, message_en=0, in_ready=0 in the reset cycle, then 1. Every message_* = 0.
//   Mux controls = `message_mux_NULL, N-type = `N_type_NULL. lane_fill=0, batch_cnt=0, timeout counter 0.
// - FSM IDLE -> FILL -> ISSUE -> IDLE.
// - in_ready = 1 in IDLE and FILL, 0 in ISSUE. Handshake = in_valid & in_ready.
// - IDLE: handshake writes lane 1; lane_fill=1; go to FILL.
//   If in_last=1, go to ISSUE instead.
// - FILL: handshake writes lane lane_fill+1 and increments lane_fill.
//   Go to ISSUE when lane_fill reaches 3 or in_last=1. Otherwise stay in FILL.
// - ISSUE: message_en=1; lanes stay stable until out_ready=1.
//   On message_en & out_ready: next cycle IDLE, message_en=0, all lanes cleared to NULL codes and 0 payload, lane_fill=0, batch_cnt+1.
// - Latency: 1 cycle from the accepting handshake of the final message to message_en=1.
//   One-cycle bubble after issue: no accept during ISSUE.
// - Lane order is arrival order, lane 1 first. Unfilled lanes always carry NULL codes, so extractors output `defaut_infor.
// - Held in ISSUE (out_ready=0): no state changes and no accepts; outputs stable.
// - rst mid-batch: partial batch discarded with no issue; batch_cnt=0.
// - Simultaneous in_valid & out_ready in ISSUE: in_valid ignored (in_ready=0) and is accepted next cycle in IDLE.
// CONFIGURATION
// - `define BATCH_TIMEOUT_EN on: in FILL, a 5-bit counter increments each cycle without a handshake and resets on handshake.
//   When it reaches TIMEOUT-1, the FSM goes to ISSUE with the partial batch.
// - BATCH_TIMEOUT_EN off: no counter; a partial batch waits in FILL until lane 3 fills or in_last=1.
// STRUCTURE
// - para_def.v gains `message_mux_NULL, `N_type_NULL and the state encodings (2 bits): `SCH_IDLE, `SCH_FILL, `SCH_ISSUE.
// - One sub-module, stage5_lane_reg: per-lane register holding payload/mux/ntype with load and clear; instantiated 3x.
// - FSM, fill counter, timeout and batch_cnt stay in the top module.
// TESTING
// - 3 back-to-back msgs (mux=`message_mux_N, ntype=`N_type_N), out_ready=1
//   -> message_en=1 one cycle after 3rd accept; lanes in order; lane_fill=3; batch_cnt=1.
// - 2 msgs, 2nd with in_last=1 -> ISSUE with lane_fill=2; lane 3 mux=`message_mux_NULL; extractor EBSN4_3=`defaut_infor.
// - ISSUE with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0 throughout; outputs stable; accept in IDLE after release.
// - rst asserted after 2 accepts -> next cycle all outputs at reset values; following 3 msgs form a clean batch, batch_cnt=1.
// - BATCH_TIMEOUT_EN, 1 msg then idle -> ISSUE after TIMEOUT=16 idle cycles with lane_fill=1; without macro, no issue after 100 cycles.
// - Preload batch_cnt to 0xFFFF via 65535 issues (or force) -> next issue gives batch_cnt=0.

Source files
------------

// File: rtl/stage5_lane_scheduler_pkg.sv
// Shared widths, NULL codes, FSM encodings and the lane record for the
// stage-5 lane scheduler.
package stage5_lane_scheduler_pkg;

    localparam int MSG_W   = 32;   // payload width per lane
    localparam int MUX_W   = 4;    // message mux-control width
    localparam int NT_W    = 4;    // N-type control width
    localparam int TIMEOUT = 16;   // idle cycles before a partial batch is flushed

    localparam logic [MUX_W-1:0] MESSAGE_MUX_NULL = 4'hF;
    localparam logic [MUX_W-1:0] MESSAGE_MUX_N    = 4'h1;
    localparam logic [NT_W-1:0]  N_TYPE_NULL      = 4'hF;
    localparam logic [NT_W-1:0]  N_TYPE_N         = 4'h2;

    localparam logic [1:0] SCH_IDLE  = 2'd0;
    localparam logic [1:0] SCH_FILL  = 2'd1;
    localparam logic [1:0] SCH_ISSUE = 2'd2;

    typedef struct packed {
        logic [MSG_W-1:0] msg;
        logic [MUX_W-1:0] mux;
        logic [NT_W-1:0]  nt;
    } lane_t;

    // Empty lane: zero payload and NULL codes so extractors emit their default.
    localparam lane_t NULL_LANE = '{msg: '0, mux: MESSAGE_MUX_NULL, nt: N_TYPE_NULL};

endpackage

// File: rtl/stage5_lane_scheduler_if.sv
// Upstream valid/ready stream plus the 3-lane batch bus toward stage 5.
// master = producer/consumer side (bench), slave = scheduler.
interface stage5_lane_scheduler_if;
    import stage5_lane_scheduler_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [MSG_W-1:0] in_message;
    logic [MUX_W-1:0] in_mux;
    logic [NT_W-1:0]  in_ntype;
    logic             in_last;
    logic             out_ready;
    logic             message_en;
    logic [MSG_W-1:0] message_1, message_2, message_3;
    logic [MUX_W-1:0] message_mux_control_m1, message_mux_control_m2, message_mux_control_m3;
    logic [NT_W-1:0]  N_type_control_m1, N_type_control_m2, N_type_control_m3;
    logic [1:0]       lane_fill;
    logic [15:0]      batch_cnt;

    modport master (
        output in_valid, in_message, in_mux, in_ntype, in_last, out_ready,
        input  in_ready, message_en, message_1, message_2, message_3,
               message_mux_control_m1, message_mux_control_m2, message_mux_control_m3,
               N_type_control_m1, N_type_control_m2, N_type_control_m3,
               lane_fill, batch_cnt
    );

    modport slave (
        input  in_valid, in_message, in_mux, in_ntype, in_last, out_ready,
        output in_ready, message_en, message_1, message_2, message_3,
               message_mux_control_m1, message_mux_control_m2, message_mux_control_m3,
               N_type_control_m1, N_type_control_m2, N_type_control_m3,
               lane_fill, batch_cnt
    );

endinterface

// File: rtl/stage5_lane_reg.sv
// One batch lane: payload/mux/ntype register with load and clear to NULL.
module stage5_lane_reg
    import stage5_lane_scheduler_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clr,
    input  lane_t d,
    output lane_t q
);

    // Clear wins over load; a cleared lane carries NULL codes.
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= NULL_LANE;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/stage5_lane_scheduler.sv
// Packs the parsed-message stream into 3-lane batches for stage 5.
// Optional feature macro: BATCH_TIMEOUT_EN (flush a partial batch after
// TIMEOUT idle cycles in FILL). Default build waits for lane 3 or in_last.
module stage5_lane_scheduler
    import stage5_lane_scheduler_pkg::*;
(
    input logic                    clk,
    input logic                    rst,
    stage5_lane_scheduler_if.slave bus
);

    logic [1:0]  state, state_nx;
    logic [1:0]  fill;
    logic [15:0] batch_q;
    logic        hs, issue_done, to_hit;
    logic [2:0]  load;
    lane_t       din;
    lane_t       lq [3];

    // No accepts in the reset cycle or while a batch is on the bus.
    assign bus.in_ready = ~rst & (state != SCH_ISSUE);
    assign hs           = bus.in_valid & bus.in_ready;
    assign issue_done   = (state == SCH_ISSUE) & bus.out_ready;
    assign din          = '{msg: bus.in_message, mux: bus.in_mux, nt: bus.in_ntype};

`ifdef BATCH_TIMEOUT_EN
    logic [4:0] to_cnt;

    assign to_hit = (state == SCH_FILL) & ~hs & (to_cnt == 5'(TIMEOUT - 1));

    // Idle-cycle counter; only runs while a partial batch waits in FILL.
    always_ff @(posedge clk) begin
        if (rst || state != SCH_FILL || hs || to_hit)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 5'd1;
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state: IDLE -> FILL -> ISSUE -> IDLE, with in_last/full/timeout exits.
    always_comb begin
        state_nx = state;
        case (state)
            SCH_IDLE:  if (hs) state_nx = bus.in_last ? SCH_ISSUE : SCH_FILL;
            SCH_FILL: begin
                if (hs) state_nx = (fill == 2'd2 || bus.in_last) ? SCH_ISSUE : SCH_FILL;
                else if (to_hit) state_nx = SCH_ISSUE;
            end
            SCH_ISSUE: if (bus.out_ready) state_nx = SCH_IDLE;
            default:   state_nx = SCH_IDLE;
        endcase
    end

    // State, fill count and issued-batch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCH_IDLE;
            fill    <= '0;
            batch_q <= '0;
        end else begin
            state <= state_nx;
            if (issue_done) begin
                fill    <= '0;
                batch_q <= batch_q + 16'd1;
            end else if (hs) begin
                fill <= fill + 2'd1;
            end
        end
    end

    // The next free lane is the one indexed by the current fill count.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_lane
            assign load[g] = hs & (fill == 2'(g));
            stage5_lane_reg u_lane (
                .clk (clk),
                .rst (rst),
                .load(load[g]),
                .clr (issue_done),
                .d   (din),
                .q   (lq[g])
            );
        end
    endgenerate

    assign bus.message_en             = (state == SCH_ISSUE);
    assign bus.lane_fill              = fill;
    assign bus.batch_cnt              = batch_q;
    assign bus.message_1              = lq[0].msg;
    assign bus.message_2              = lq[1].msg;
    assign bus.message_3              = lq[2].msg;
    assign bus.message_mux_control_m1 = lq[0].mux;
    assign bus.message_mux_control_m2 = lq[1].mux;
    assign bus.message_mux_control_m3 = lq[2].mux;
    assign bus.N_type_control_m1      = lq[0].nt;
    assign bus.N_type_control_m2      = lq[1].nt;
    assign bus.N_type_control_m3      = lq[2].nt;

endmodule
